// File: rtl/sha256_schedule_ctrl.sv
// Sequencer for the SHA-256 message scheduler: loads 16 message words, then
// steps round_t 0..63, holding each expanded round for the W[t] calculation.
module sha256_schedule_ctrl #(
    parameter int ROUND_HOLD = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic        msg_valid,
    input  logic [31:0] msg_word,
    output logic        msg_ready,
    output logic        start_new_block,
    output logic        write_enable_in,
    output logic [3:0]  message_word_addr,
    output logic [31:0] message_word_in,
    output logic [5:0]  round_t,
    output logic        wt_valid,
    output logic        last_round,
    output logic        block_done,
    output logic        busy
);

    localparam int HW = (ROUND_HOLD > 1) ? $clog2(ROUND_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(ROUND_HOLD - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [4:0]    load_cnt, load_cnt_nxt;
    logic [5:0]    round_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic          first_load, first_load_nxt;
    logic          accept;
    logic          round_step;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            load_cnt   <= '0;
            round_t    <= '0;
            hold_cnt   <= '0;
            first_load <= 1'b0;
        end else begin
            state      <= state_nxt;
            load_cnt   <= load_cnt_nxt;
            round_t    <= round_nxt;
            hold_cnt   <= hold_nxt;
            first_load <= first_load_nxt;
        end
    end

    always_comb begin
        msg_ready         = (state == S_LOAD);
        accept            = msg_valid & msg_ready;
        write_enable_in   = accept;
        message_word_in   = msg_word;
        message_word_addr = load_cnt[3:0];
        start_new_block   = first_load;
        busy              = (state != S_IDLE);
        // Unexpanded rounds advance every cycle; expanded ones wait out the hold window.
        round_step        = (state == S_ROUND) & ~abort &
                            ((round_t < 6'd16) | (hold_cnt == HOLD_MAX));
        wt_valid          = round_step;
        last_round        = round_step & (round_t == 6'd63);
        block_done        = (state == S_DONE) & ~abort;
    end

    always_comb begin
        state_nxt      = state;
        load_cnt_nxt   = load_cnt;
        round_nxt      = round_t;
        hold_nxt       = hold_cnt;
        first_load_nxt = 1'b0;
        if (abort) begin
            state_nxt    = S_IDLE;
            load_cnt_nxt = '0;
            round_nxt    = '0;
            hold_nxt     = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    load_cnt_nxt = '0;
                    round_nxt    = '0;
                    hold_nxt     = '0;
                    if (start) begin
                        state_nxt      = S_LOAD;
                        first_load_nxt = 1'b1;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        load_cnt_nxt = load_cnt + 5'd1;
                        if (load_cnt == 5'd15) begin
                            state_nxt = S_ROUND;
                            round_nxt = '0;
                            hold_nxt  = '0;
                        end
                    end
                end
                S_ROUND: begin
                    if (round_step) begin
                        hold_nxt = '0;
                        if (round_t == 6'd63) begin
                            state_nxt = S_DONE;
                            round_nxt = '0;
                        end else begin
                            round_nxt = round_t + 6'd1;
                        end
                    end else if (round_t >= 6'd16) begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state_nxt    = S_IDLE;
                    load_cnt_nxt = '0;
                    round_nxt    = '0;
                    hold_nxt     = '0;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_schedule_ctrl.sv
// Directed bench for sha256_schedule_ctrl: one instance with the default hold
// of 5 and one with ROUND_HOLD = 1, driven one at a time through sel.
module tb_sha256_schedule_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, start, abort, msg_valid, sel;
    logic [31:0] msg_word;
    logic        start_a, start_b, abort_a, abort_b, msg_valid_a, msg_valid_b;

    logic        ready_a, snb_a, we_a, wt_a, last_a, done_a, busy_a;
    logic [3:0]  addr_a;
    logic [31:0] mwi_a;
    logic [5:0]  round_a;
    logic        ready_b, snb_b, we_b, wt_b, last_b, done_b, busy_b;
    logic [3:0]  addr_b;
    logic [31:0] mwi_b;
    logic [5:0]  round_b;

    logic        m_ready, m_snb, m_we, m_wt, m_last, m_done, m_busy;
    logic [3:0]  m_addr;
    logic [31:0] m_mwi;
    logic [5:0]  m_round;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] words [16];

    assign start_a     = start & ~sel;
    assign start_b     = start & sel;
    assign abort_a     = abort & ~sel;
    assign abort_b     = abort & sel;
    assign msg_valid_a = msg_valid & ~sel;
    assign msg_valid_b = msg_valid & sel;

    sha256_schedule_ctrl dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort_a),
        .msg_valid(msg_valid_a), .msg_word(msg_word), .msg_ready(ready_a),
        .start_new_block(snb_a), .write_enable_in(we_a), .message_word_addr(addr_a),
        .message_word_in(mwi_a), .round_t(round_a), .wt_valid(wt_a),
        .last_round(last_a), .block_done(done_a), .busy(busy_a)
    );

    sha256_schedule_ctrl #(.ROUND_HOLD(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort_b),
        .msg_valid(msg_valid_b), .msg_word(msg_word), .msg_ready(ready_b),
        .start_new_block(snb_b), .write_enable_in(we_b), .message_word_addr(addr_b),
        .message_word_in(mwi_b), .round_t(round_b), .wt_valid(wt_b),
        .last_round(last_b), .block_done(done_b), .busy(busy_b)
    );

    always_comb begin
        m_ready = sel ? ready_b : ready_a;
        m_snb   = sel ? snb_b   : snb_a;
        m_we    = sel ? we_b    : we_a;
        m_addr  = sel ? addr_b  : addr_a;
        m_mwi   = sel ? mwi_b   : mwi_a;
        m_round = sel ? round_b : round_a;
        m_wt    = sel ? wt_b    : wt_a;
        m_last  = sel ? last_b  : last_a;
        m_done  = sel ? done_b  : done_a;
        m_busy  = sel ? busy_b  : busy_a;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc_end();
        @(posedge clk);
        #1;
    endtask

    // Start a block and feed nwords words, inserting gap idle cycles between words.
    task automatic load_block(input int gap, input int nwords);
        int lc;
        lc = 0;
        start = 1'b1;
        @(negedge clk);
        chk("start_idle_busy", m_busy, 0);
        cyc_end();
        start = 1'b0;
        for (int i = 0; i < nwords; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    msg_valid = 1'b0;
                    msg_word  = 32'hDEAD_0000 | i;
                    @(negedge clk);
                    chk("gap_we", m_we, 0);
                    chk("gap_snb", m_snb, 0);
                    lc += int'(m_ready);
                    cyc_end();
                end
            end
            msg_valid = 1'b1;
            msg_word  = words[i];
            @(negedge clk);
            chk("load_we", m_we, 1);
            chk("load_addr", m_addr, i);
            chk("load_wdata", m_mwi, words[i]);
            chk("load_snb", m_snb, (i == 0));
            lc += int'(m_ready);
            cyc_end();
        end
        msg_valid = 1'b0;
        if (nwords == 16) chk("load_cycles", lc, 16 + 15 * gap);
    endtask

    // Follow the rounds cycle by cycle after the last accept; optional abort and start pulses.
    task automatic watch_block(input int hold, input int abort_k, input bit pulse_start);
        int total, pulses, exp_r;
        bit exp_wt;
        total  = 16 + 48 * hold;
        pulses = 0;
        for (int k = 1; k <= total + 1; k++) begin
            if (k <= 16) begin
                exp_r = k - 1; exp_wt = 1'b1;
            end else if (k <= total) begin
                exp_r  = 16 + (k - 17) / hold;
                exp_wt = (((k - 17) % hold) == hold - 1);
            end else begin
                exp_r = 0; exp_wt = 1'b0;
            end
            start = pulse_start && (k == 11 || k == total + 1);
            abort = (k == abort_k);
            if (abort) exp_wt = 1'b0;
            @(negedge clk);
            chk("round_t", m_round, exp_r);
            chk("wt_valid", m_wt, exp_wt);
            chk("last_round", m_last, (exp_wt && exp_r == 63));
            chk("block_done", m_done, (k == total + 1) && !abort);
            chk("round_ready", m_ready, 0);
            pulses += int'(m_wt);
            cyc_end();
            start = 1'b0;
            if (k == abort_k) begin
                abort = 1'b0;
                @(negedge clk);
                chk("abort_busy", m_busy, 0);
                chk("abort_round", m_round, 0);
                chk("abort_done", m_done, 0);
                cyc_end();
                return;
            end
        end
        chk("wt_pulses", pulses, 64);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            chk("post_busy", m_busy, 0);
            chk("post_done", m_done, 0);
            chk("post_snb", m_snb, 0);
            cyc_end();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; msg_valid = 1'b0; sel = 1'b0;
        msg_word = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready_a, 0);
        chk("rst_snb", snb_a, 0);
        chk("rst_round", round_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_wt", wt_a, 0);
        chk("rst_mwi", mwi_a, 32'h1234_5678);
        chk("rst_busy_b", busy_b, 0);
        reset_n = 1'b1;
        cyc_end();

        // Nominal block: "abc" padded
        for (int i = 0; i < 16; i++) words[i] = 32'h0;
        words[0]  = 32'h6162_6380;
        words[15] = 32'h0000_0018;
        load_block(0, 16);
        watch_block(5, 0, 1'b0);

        // Bursty input
        for (int i = 0; i < 16; i++) words[i] = 32'h0101_0101 * (i + 1);
        load_block(1, 16);
        watch_block(5, 0, 1'b0);

        // Start pulses while busy are ignored
        load_block(0, 16);
        watch_block(5, 0, 1'b1);

        // Abort beats start in IDLE
        start = 1'b1; abort = 1'b1;
        cyc_end();
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("abort_start_busy", busy_a, 0);
        cyc_end();

        // Abort at round 20, hold 2, then a full block
        load_block(0, 16);
        watch_block(5, 39, 1'b0);
        load_block(0, 16);
        watch_block(5, 0, 1'b0);

        // Reset after 7 words
        load_block(0, 7);
        msg_valid = 1'b1;
        msg_word  = 32'hCAFE_F00D;
        @(negedge clk);
        chk("midload_addr", addr_a, 7);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstm_ready", ready_a, 0);
        chk("rstm_we", we_a, 0);
        chk("rstm_addr", addr_a, 0);
        chk("rstm_busy", busy_a, 0);
        chk("rstm_snb", snb_a, 0);
        chk("rstm_mwi", mwi_a, 32'hCAFE_F00D);
        cyc_end();
        msg_valid = 1'b0;
        reset_n = 1'b1;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            chk("rel_snb", snb_a, 0);
            chk("rel_busy", busy_a, 0);
            cyc_end();
        end
        load_block(0, 16);
        watch_block(5, 0, 1'b0);

        // ROUND_HOLD = 1 instance
        sel = 1'b1;
        load_block(0, 16);
        watch_block(1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
